// File: rtl/bht_branch_predictor_if.sv
// Query (IF side) and training/statistics (commit side) signals of the branch predictor.
// The master modport is the pipeline; the slave modport is the predictor.
interface bht_branch_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = 8
);
  logic [ADDR_WIDTH-1:0] query_pc;
  logic [31:0]           query_inst;
  logic                  predicted_jump;
  logic [ADDR_WIDTH-1:0] predicted_target_pc;
  logic [IDX_BITS-1:0]   query_index;
  logic                  upd_valid;
  logic [IDX_BITS-1:0]   upd_index;
  logic                  upd_taken;
  logic                  upd_mispredict;
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;

  modport master (
    output query_pc, query_inst, upd_valid, upd_index, upd_taken, upd_mispredict,
    input  predicted_jump, predicted_target_pc, query_index, stat_branches, stat_mispredicts
  );

  modport slave (
    input  query_pc, query_inst, upd_valid, upd_index, upd_taken, upd_mispredict,
    output predicted_jump, predicted_target_pc, query_index, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bht_branch_predictor.sv
// 2-bit saturating-counter BHT: combinational 0-cycle query, 1-cycle commit-ordered training.
// No backpressure; rdy=0 freezes all state. Define PRED_GSHARE_EN to XOR global history into the index.
module bht_branch_predictor #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         IDX_BITS   = 8,
  parameter int         HIST_BITS  = 8,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   rdy,
  bht_branch_predictor_if.slave bp
);
  localparam int          DEPTH      = 2 ** IDX_BITS;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

  logic [1:0]            bht [DEPTH];
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;
  logic [IDX_BITS-1:0]   pc_index;
  logic [IDX_BITS-1:0]   query_index;
  logic signed [31:0]    jimm;
  logic signed [31:0]    bimm;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] pc_jal;
  logic [ADDR_WIDTH-1:0] pc_branch;
  logic                  predicted_jump;
  logic [ADDR_WIDTH-1:0] predicted_target_pc;
  logic [1:0]            cnt_cur;
  logic [1:0]            cnt_next;
  logic                  upd_accept;

  assign pc_index = bp.query_pc[IDX_BITS+1:2];

`ifdef PRED_GSHARE_EN
  logic [HIST_BITS-1:0] ghr;

  assign query_index = pc_index ^ IDX_BITS'(ghr);

  // History follows commit order only; there is no speculative copy to repair on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_accept) begin
      ghr <= {ghr[HIST_BITS-2:0], bp.upd_taken};
    end
  end
`else
  assign query_index = pc_index;
`endif

  assign jimm = {{12{bp.query_inst[31]}}, bp.query_inst[19:12], bp.query_inst[20],
                 bp.query_inst[30:21], 1'b0};
  assign bimm = {{20{bp.query_inst[31]}}, bp.query_inst[7], bp.query_inst[30:25],
                 bp.query_inst[11:8], 1'b0};

  assign pc_plus4  = bp.query_pc + ADDR_WIDTH'(4);
  assign pc_jal    = bp.query_pc + ADDR_WIDTH'(jimm);
  assign pc_branch = bp.query_pc + ADDR_WIDTH'(bimm);

  always_comb begin
    predicted_jump      = 1'b0;
    predicted_target_pc = pc_plus4;
    case (bp.query_inst[6:0])
      OP_JAL: begin
        predicted_jump      = 1'b1;
        predicted_target_pc = pc_jal;
      end
      OP_BRANCH: begin
        predicted_jump      = bht[query_index][1];
        predicted_target_pc = bht[query_index][1] ? pc_branch : pc_plus4;
      end
      default: ;
    endcase
  end

  assign upd_accept = bp.upd_valid & rdy;
  assign cnt_cur    = bht[bp.upd_index];

  always_comb begin
    cnt_next = cnt_cur;
    if (bp.upd_taken) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  // Reads above see the pre-update table, so a same-cycle query gets the old counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= CNT_INIT;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_accept) begin
      bht[bp.upd_index] <= cnt_next;
      stat_branches     <= stat_branches + 32'd1;
      if (bp.upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  assign bp.predicted_jump      = predicted_jump;
  assign bp.predicted_target_pc = predicted_target_pc;
  assign bp.query_index         = query_index;
  assign bp.stat_branches       = stat_branches;
  assign bp.stat_mispredicts    = stat_mispredicts;
endmodule
